pipeline_mdu: RTL and testbench
===============================

Name: pipeline_mdu

Overview:
- Parametrised iterative multiply/divide unit for the EXE stage of the 5-stage pipelined CPU.
- Replaces the combinational multiplier.
- Executes MULT/MULTU/DIV/DIVU over WIDTH-bit operands and owns the HI/LO registers.
- Uses the pipeline's valid/allowin handshake, so EXE deasserts es_ready_go while the unit is busy.
- Supports flush for a cancelled instruction.

Parameters:
- WIDTH, 32, operand width in bits (>=4, even); HI, LO and each result half are WIDTH bits wide.
- LO_RESET, 0, reset value of HI and LO.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EXE presents an MDU operation
- in_ready  out  1  unit accepts an operation this cycle
- in_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- in_src1  in  WIDTH  rs value (multiplicand/dividend)
- in_src2  in  WIDTH  rt value (multiplier/divisor)
- flush  in  1  cancel any in-flight or completed-but-unretired operation
- out_valid  out  1  result ready
- out_allowin  in  1  downstream retires the result
- out_hi  out  WIDTH  product high half / remainder
- out_lo  out  WIDTH  product low half / quotient
- hi_o  out  WIDTH  architectural HI register
- lo_o  out  WIDTH  architectural LO register
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, out_valid=0, out_hi=out_lo=0, hi_o=lo_o=LO_RESET, iteration counter=0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- in_ready = (state==IDLE) && !flush. An operation is accepted on an edge where in_valid && in_ready.
- Accept edge: latch op and operand magnitudes. Signed ops use absolute values and record result signs; unsigned ops use raw values. Go to CALC with counter=WIDTH.
- CALC: one bit per cycle for exactly WIDTH cycles. Multiply is shift-add on a 2*WIDTH accumulator. Divide is restoring division, one quotient bit per cycle. Decrement counter each cycle; at counter==1, go to FIX.
- FIX, one cycle, applies signs and special cases:
  - Signed multiply: negate the 2*WIDTH product if signs differ.
  - Signed divide: quotient negative if signs differ; remainder takes the dividend's sign.
  - Divide by zero (any divide op): lo=all ones, hi=src1 (original, unmodified).
  - Signed overflow (src1=-2^(WIDTH-1), src2=-1): lo=src1, hi=0.
  - Go to DONE.
- Fixed latency: out_valid rises after the (WIDTH+2)th rising edge following the accept edge, 34 edges for WIDTH=32. Special cases take the same latency.
- DONE: out_valid=1; out_hi/out_lo hold stable while !out_allowin.
  - On an edge with out_allowin: hi_o<=out_hi, lo_o<=out_lo, state=IDLE, out_valid=0.
  - The next operation can be accepted in the cycle after retirement, not the same cycle.
- flush: on any edge with flush=1 and state!=IDLE, state=IDLE, out_valid=0, HI/LO unchanged. Flush has priority over retirement in DONE. Flush in IDLE is a no-op and blocks acceptance that cycle.
- in_src1/in_src2/in_op are sampled only on the accept edge; later changes are ignored.
- hi_o/lo_o change only on retirement; they are never driven by intermediate values.
- Arithmetic: products use an internal 2*WIDTH accumulator; out_hi=product[2W-1:W], out_lo=product[W-1:0]. All negation is two's complement modulo 2^WIDTH (or 2^(2W) for products).

Test Plan:
- MULTU with WIDTH=32, src1=0xFFFFFFFF, src2=0xFFFFFFFF, out_allowin=1 -> out_valid exactly 34 edges after accept; hi=0xFFFFFFFE, lo=0x00000001; hi_o/lo_o take these values one edge later; in_ready=1 the following cycle.
- MULT with src1=-3 (0xFFFFFFFD), src2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV with -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU with 100/0 -> lo=0xFFFFFFFF, hi=100 after full latency. DIV with 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Backpressure: DIVU 17/5, out_allowin=0 for 10 cycles -> out_valid stays 1, lo=3 and hi=2 stable, in_ready=0, hi_o/lo_o unchanged. Raise out_allowin -> retired in 1 edge.
- Flush mid-CALC (edge 10) and in DONE with out_allowin=1 -> state IDLE next edge, out_valid=0, hi_o/lo_o keep their prior values. New op accepted the following cycle completes correctly.
- Async reset asserted mid-CALC between edges -> immediately busy=0, out_valid=0, hi_o=lo_o=LO_RESET. Repeat the first two scenarios with WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 10 edges.

Source files
------------

// File: rtl/pipeline_mdu.sv
// Iterative multiply/divide unit for the EXE stage.
// Computes MULT/MULTU/DIV/DIVU one bit per cycle and owns the architectural
// HI/LO registers, which are written only when a result is retired.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready. A result is retired on a rising edge where
// out_valid && out_allowin && !flush. out_hi/out_lo are stable while
// out_valid is high. flush cancels whatever the unit holds and wins over
// retirement.
module pipeline_mdu #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] LO_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_allowin,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;   // quotient / product must be negated
    logic               neg_rem;   // remainder takes the dividend's sign
    logic               div_zero;
    logic               ovf;
    logic [WIDTH-1:0]   src1_raw;  // original dividend for divide-by-zero
    logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // {hi, lo} working register

    // Operand decode on the accept edge: magnitudes and result signs.
    logic               in_signed;
    logic               s1_neg, s2_neg;
    logic [WIDTH-1:0]   mag1, mag2;

    // One-bit step and sign/special-case fixup.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] calc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign in_ready  = (state == S_IDLE) && !flush;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Decode operands into magnitudes for the signed ops.
    always_comb begin
        in_signed = ~in_op[0];
        s1_neg    = in_signed & in_src1[WIDTH-1];
        s2_neg    = in_signed & in_src2[WIDTH-1];
        mag1      = s1_neg ? -in_src1 : in_src1;
        mag2      = s2_neg ? -in_src2 : in_src2;
    end

    // One iteration: shift-add multiply or restoring-division step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        if (!is_div)
            calc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            calc_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            calc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Apply result signs and the divide special cases.
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            fix_hi = src1_raw;
            fix_lo = '1;
        end else if (ovf) begin
            fix_hi = '0;
            fix_lo = src1_raw;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // Control FSM, datapath registers and HI/LO retirement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            src1_raw  <= '0;
            opb       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_hi    <= '0;
            out_lo    <= '0;
            hi_o      <= LO_RESET;
            lo_o      <= LO_RESET;
        end else if (flush && state != S_IDLE) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        is_div   <= in_op[1];
                        neg_res  <= s1_neg ^ s2_neg;
                        neg_rem  <= s1_neg;
                        div_zero <= in_op[1] && (in_src2 == '0);
                        ovf      <= in_op[1] && in_signed &&
                                    (in_src1 == MIN_NEG) && (in_src2 == '1);
                        src1_raw <= in_src1;
                        opb      <= in_op[1] ? mag2 : mag1;
                        acc      <= {{WIDTH{1'b0}}, (in_op[1] ? mag1 : mag2)};
                        cnt      <= CNT_INIT;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= calc_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= S_FIX;
                end
                S_FIX: begin
                    out_hi <= fix_hi;
                    out_lo <= fix_lo;
                    state  <= S_DONE;
                end
                default: begin
                    // First DONE cycle raises out_valid; later cycles wait for retirement.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_allowin) begin
                        hi_o      <= out_hi;
                        lo_o      <= out_lo;
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mdu.sv
// Directed bench for pipeline_mdu: a 32-bit instance with a non-zero
// LO_RESET and an 8-bit instance. Expected results are queued at issue
// time; monitors pop and compare on every retirement.
module tb_pipeline_mdu;

    localparam logic [31:0] RST_VAL = 32'h1234_5678;
    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_allowin, busy;
    logic [1:0]  in_op, dbg_state;
    logic [31:0] in_src1, in_src2, out_hi, out_lo, hi_o, lo_o;

    logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_busy;
    logic [1:0]  w8_in_op, w8_dbg_state;
    logic [7:0]  w8_in_src1, w8_in_src2, w8_out_hi, w8_out_lo, w8_hi_o, w8_lo_o;

    logic [63:0] exp_q[$];
    logic [15:0] exp8_q[$];
    logic [63:0] last_exp;
    int          n_vec = 0;
    int          n_err = 0;

    // Clock and reset
    always #5 clk = ~clk;

    pipeline_mdu #(.WIDTH(32), .LO_RESET(RST_VAL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_hi(out_hi),
        .out_lo(out_lo), .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .dbg_state(dbg_state)
    );

    pipeline_mdu #(.WIDTH(8), .LO_RESET(8'h00)) dut8 (
        .clk(clk), .reset(reset), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .in_op(w8_in_op), .in_src1(w8_in_src1), .in_src2(w8_in_src2), .flush(1'b0),
        .out_valid(w8_out_valid), .out_allowin(1'b1), .out_hi(w8_out_hi),
        .out_lo(w8_out_lo), .hi_o(w8_hi_o), .lo_o(w8_lo_o), .busy(w8_busy),
        .dbg_state(w8_dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare on each retirement
    always @(negedge clk) begin
        if (!reset && out_valid && out_allowin && !flush) begin
            if (exp_q.size() == 0) chk("unexpected_result32", {out_hi, out_lo}, 64'hx);
            else chk("result32", {out_hi, out_lo}, exp_q.pop_front());
        end
        if (!reset && w8_out_valid) begin
            if (exp8_q.size() == 0) chk("unexpected_result8", {48'h0, w8_out_hi, w8_out_lo}, 64'hx);
            else chk("result8", {48'h0, w8_out_hi, w8_out_lo}, {48'h0, exp8_q.pop_front()});
        end
    end

    // Driver: wait for in_ready, present one op, optionally check latency.
    // Called and returns at 1 time unit after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push, input bit wait_done);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 2'($urandom_range(0, 3)); in_src1 = $urandom; in_src2 = $urandom;
        if (wait_done) begin
            n = 0;
            while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
            chk("latency32", 64'(n), 64'd34);
        end
    endtask

    // One edge after out_valid with out_allowin=1: result lands in HI/LO
    task automatic retire_check(input logic [63:0] exp);
        @(posedge clk); #1;
        chk("hi_o", {32'h0, hi_o}, {32'h0, exp[63:32]});
        chk("lo_o", {32'h0, lo_o}, {32'h0, exp[31:0]});
        chk("ready_after_retire", {63'h0, in_ready}, 64'h1);
        last_exp = exp;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        int n;
        n = 0;
        while (!w8_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        w8_in_valid = 1'b1; w8_in_op = op; w8_in_src1 = a; w8_in_src2 = b;
        exp8_q.push_back(exp);
        @(posedge clk); #1;
        w8_in_valid = 1'b0; w8_in_src1 = 8'($urandom); w8_in_src2 = 8'($urandom);
        n = 0;
        while (!w8_out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("latency8", 64'(n), 64'd10);
        @(posedge clk); #1;
        chk("hi_o8", {56'h0, w8_hi_o}, {56'h0, exp[15:8]});
        chk("lo_o8", {56'h0, w8_lo_o}, {56'h0, exp[7:0]});
    endtask

    initial begin
        #200000;
        n_vec++; n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; out_allowin = 1'b1;
        w8_in_valid = 1'b0; w8_in_op = 2'd0; w8_in_src1 = '0; w8_in_src2 = '0;
        last_exp = {RST_VAL, RST_VAL};
        @(posedge clk); #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out", {out_hi, out_lo}, 64'h0);
        chk("rst_hilo", {hi_o, lo_o}, {RST_VAL, RST_VAL});
        chk("rst_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic arithmetic and special cases, retired immediately
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1, 1);
        retire_check(64'hFFFF_FFFE_0000_0001);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1);
        retire_check(64'hFFFF_FFFF_FFFF_FFEB);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1, 1);
        retire_check(64'hFFFF_FFFF_FFFF_FFFD);
        issue(OP_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1, 1);
        retire_check(64'h0000_0064_FFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1, 1);
        retire_check(64'h0000_0000_8000_0000);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1, 1);
        retire_check(64'h0000_0001_FFFF_FFFD);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 1, 1);
        retire_check(64'hFFFF_FFF9_FFFF_FFFF);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 1);
        retire_check(64'h4000_0000_0000_0000);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1, 1);
        retire_check(64'h0000_0000_FFFF_FFFF);

        // Backpressure: result held for 10 cycles, then retired
        out_allowin = 1'b0;
        issue(OP_DIVU, 32'd17, 32'd5, 64'h0000_0002_0000_0003, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_out", {out_hi, out_lo}, 64'h0000_0002_0000_0003);
            chk("bp_ready", {63'h0, in_ready}, 64'h0);
            chk("bp_hilo", {hi_o, lo_o}, last_exp);
        end
        out_allowin = 1'b1;
        retire_check(64'h0000_0002_0000_0003);
        chk("bp_valid_drop", {63'h0, out_valid}, 64'h0);

        // Flush on the 10th edge after accept, mid-CALC
        issue(OP_MULTU, 32'd5, 32'd5, 64'h0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc_busy", {63'h0, busy}, 64'h0);
        chk("flush_calc_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_calc_hilo", {hi_o, lo_o}, last_exp);
        issue(OP_MULTU, 32'd6, 32'd7, 64'd42, 1, 1);
        retire_check(64'd42);

        // Flush in DONE wins over retirement
        out_allowin = 1'b0;
        issue(OP_DIVU, 32'd50, 32'd7, 64'h0, 0, 1);
        flush = 1'b1; out_allowin = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_done_busy", {63'h0, busy}, 64'h0);
        chk("flush_done_hilo", {hi_o, lo_o}, last_exp);
        issue(OP_DIVU, 32'd50, 32'd7, 64'h0000_0001_0000_0007, 1, 1);
        retire_check(64'h0000_0001_0000_0007);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; in_valid = 1'b1; in_op = OP_MULTU; in_src1 = 32'd3; in_src2 = 32'd3;
        #1 chk("flush_idle_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_busy", {63'h0, busy}, 64'h0);

        // Asynchronous reset between edges, mid-CALC
        issue(OP_MULTU, 32'd9, 32'd9, 64'h0, 0, 0);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_busy", {63'h0, busy}, 64'h0);
        chk("areset_valid", {63'h0, out_valid}, 64'h0);
        chk("areset_hilo", {hi_o, lo_o}, {RST_VAL, RST_VAL});
        chk("areset_out", {out_hi, out_lo}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 8-bit instance
        issue8(OP_MULTU, 8'hFF, 8'hFF, 16'hFE01);
        issue8(OP_MULT, 8'hFD, 8'h07, 16'hFFEB);
        issue8(OP_DIV, 8'hF9, 8'h02, 16'hFFFD);

        repeat (3) @(posedge clk);
        chk("queue32_drained", 64'(exp_q.size()), 64'd0);
        chk("queue8_drained", 64'(exp8_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
